qdr_vacc_rb_packetizer: RTL and testbench

QDR_VACC_RB_PACKETIZER -- requirements
Module: qdr_vacc_rb_packetizer

---
 rtl/qdr_vacc_pkg.sv | 17 +
 rtl/vacc_rb_commit_fifo.sv | 50 +++++
 rtl/qdr_vacc_rb_packetizer.sv | 123 ++++++++++++
 tb/tb_qdr_vacc_rb_packetizer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_vacc_pkg.sv
// rtl/qdr_vacc_pkg.sv - shared read-FSM encoding and FIFO entry layout for the vacc readback packetizer
package qdr_vacc_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // FIFO entry is {flags, offset, data}; flags sit in the top two bits.
  typedef struct packed {
    logic eop;
    logic sop;
  } ent_flags_t;

  function automatic int ent_width(input int data_w, input int off_w);
    return data_w + off_w + 2;
  endfunction

endpackage

// File: rtl/vacc_rb_commit_fifo.sv
// rtl/vacc_rb_commit_fifo.sv - packet FIFO; reader only sees words up to the committed write pointer
module vacc_rb_commit_fifo #(
  parameter int DW = 73,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          flush,
  input  logic          abort,
  input  logic          commit,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full
);

  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wr_ptr, wr_cmt, rd_ptr, base;

  // A flush in the same cycle as a write places the word right after the last committed one.
  assign base    = flush ? wr_cmt : wr_ptr;
  assign full    = (base - rd_ptr) == DEPTH;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (ce && wr_en) mem[base[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      wr_cmt <= '0;
      rd_ptr <= '0;
    end else if (ce) begin
      if (wr_en) begin
        wr_ptr <= base + PTR_ONE;
        if (commit) wr_cmt <= base + PTR_ONE;
      end else if (flush || abort) begin
        wr_ptr <= wr_cmt;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/qdr_vacc_rb_packetizer.sv
// rtl/qdr_vacc_rb_packetizer.sv - splits vacc readback vectors into offset-tagged bursts with commit/drop semantics
module qdr_vacc_rb_packetizer
  import qdr_vacc_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int VEC_LEN      = 100,
  parameter int VEC_LEN_BITS = 7,
  parameter int FIFO_AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_vld,
  input  logic                    sync,
  input  logic [31:0]             rb_burst_len_mi,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [VEC_LEN_BITS-1:0] dout_offset,
  output logic                    dout_vld,
  output logic                    dout_sop,
  output logic                    dout_eop,
  input  logic                    dout_rdy,
  output logic                    overflow,
  output logic [FIFO_AW:0]        pkt_pending
);

  localparam int ENT_W = ent_width(DATA_WIDTH, VEC_LEN_BITS);
  localparam logic [VEC_LEN_BITS-1:0] LAST_OFF = VEC_LEN_BITS'(VEC_LEN - 1);
  localparam logic [VEC_LEN_BITS-1:0] OFF_ONE  = 1;
  localparam logic [FIFO_AW-1:0]      CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0]      MAX_BM1  = '1;
  localparam logic [FIFO_AW:0]        PKT_ONE  = 1;

  logic [VEC_LEN_BITS-1:0] offset, wr_off;
  logic [FIFO_AW-1:0]      cnt, wr_cnt, blen_m1, new_bm1, cur_bm1;
  logic                    drop, drop_eff, wr_sop, wr_eop, wr_req;
  logic                    fifo_full, fifo_wr, fifo_abort, commit;
  logic [0:0]              state;
  logic                    load, rd_eop;
  logic [ENT_W-1:0]        wr_ent, rd_ent;
  ent_flags_t              wr_flags, rd_flags;

  assign new_bm1 = (rb_burst_len_mi >= 32'(MAX_BM1)) ? MAX_BM1 : rb_burst_len_mi[FIFO_AW-1:0];

  always_comb begin
    wr_off     = sync ? '0 : offset;
    wr_cnt     = sync ? '0 : cnt;
    cur_bm1    = (wr_off == '0) ? new_bm1 : blen_m1;
    wr_sop     = (wr_cnt == '0);
    wr_eop     = (wr_cnt == cur_bm1) || (wr_off == LAST_OFF);
    // Once a packet overflows, its remaining words are skipped until the next packet start.
    drop_eff   = drop && !sync && !wr_sop;
    wr_req     = din_vld && !drop_eff;
    fifo_abort = wr_req && fifo_full;
    fifo_wr    = wr_req && !fifo_full;
    commit     = fifo_wr && wr_eop;
  end

  assign wr_flags = '{eop: wr_eop, sop: wr_sop};
  assign wr_ent   = {wr_flags, wr_off, din};
  assign rd_flags = rd_ent[ENT_W-1 -: 2];

  vacc_rb_commit_fifo #(.DW(ENT_W), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .ce(ce),
    .wr_en(fifo_wr), .wr_data(wr_ent), .flush(sync), .abort(fifo_abort), .commit(commit),
    .rd_en(load), .rd_data(rd_ent), .full(fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset      <= '0;
      cnt         <= '0;
      blen_m1     <= '0;
      drop        <= 1'b0;
      overflow    <= 1'b0;
      pkt_pending <= '0;
    end else if (ce) begin
      if (sync || din_vld) blen_m1 <= cur_bm1;
      if (din_vld) begin
        offset <= (wr_off == LAST_OFF) ? '0 : wr_off + OFF_ONE;
        cnt    <= wr_eop ? '0 : wr_cnt + CNT_ONE;
        drop   <= drop_eff || fifo_abort;
      end else if (sync) begin
        offset <= '0;
        cnt    <= '0;
        drop   <= 1'b0;
      end
      if (fifo_abort) overflow <= 1'b1;
      case ({commit, rd_eop})
        2'b10:   pkt_pending <= pkt_pending + PKT_ONE;
        2'b01:   pkt_pending <= pkt_pending - PKT_ONE;
        default: pkt_pending <= pkt_pending;
      endcase
    end
  end

  // The next packet is only chained without an idle cycle if it was committed before this cycle.
  assign rd_eop = ce && (state == ST_SEND) && dout_rdy && dout_eop;
  assign load   = ce && (((state == ST_IDLE) && (pkt_pending != '0)) ||
                         ((state == ST_SEND) && dout_rdy && (!dout_eop || (pkt_pending > PKT_ONE))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dout        <= '0;
      dout_offset <= '0;
      dout_sop    <= 1'b0;
      dout_eop    <= 1'b0;
      dout_vld    <= 1'b0;
    end else if (load) begin
      state       <= ST_SEND;
      dout        <= rd_ent[DATA_WIDTH-1:0];
      dout_offset <= rd_ent[DATA_WIDTH +: VEC_LEN_BITS];
      dout_sop    <= rd_flags.sop;
      dout_eop    <= rd_flags.eop;
      dout_vld    <= 1'b1;
    end else if (rd_eop) begin
      state    <= ST_IDLE;
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qdr_vacc_rb_packetizer.sv
// tb/tb_qdr_vacc_rb_packetizer.sv - directed bench for the vacc readback packetizer
module tb_qdr_vacc_rb_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic [63:0] din = '0;
  logic        din_vld = 1'b0;
  logic        sync = 1'b0;
  logic [31:0] rb_burst_len_mi = 32'd3;
  logic [63:0] dout;
  logic [6:0]  dout_offset;
  logic        dout_vld, dout_sop, dout_eop;
  logic        dout_rdy = 1'b1;
  logic        overflow;
  logic [5:0]  pkt_pending;

  int vectors = 0;
  int miscompares = 0;
  logic [72:0] cap_q[$];
  logic [72:0] exp_q[$];
  logic [72:0] cur, stall_snap;
  logic        have_stall = 1'b0;
  logic        in_pkt = 1'b0;

  qdr_vacc_rb_packetizer dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din), .din_vld(din_vld), .sync(sync),
    .rb_burst_len_mi(rb_burst_len_mi), .dout(dout), .dout_offset(dout_offset),
    .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_rdy(dout_rdy),
    .overflow(overflow), .pkt_pending(pkt_pending)
  );

  always #5 clk = ~clk;

  assign cur = {dout_sop, dout_eop, dout_offset, dout};

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepted words are captured mid-cycle; stalls must hold, open packets must not gap.
  always @(negedge clk) begin
    if (!rst) begin
      in_pkt = 1'b0;
      have_stall = 1'b0;
    end else begin
      if (have_stall) chk("stall_hold", {dout_vld, cur}, {1'b1, stall_snap});
      if (in_pkt) chk("no_gap", {72'd0, dout_vld}, 73'd1);
      have_stall = ce && dout_vld && !dout_rdy;
      stall_snap = cur;
      if (ce && dout_vld && dout_rdy) begin
        cap_q.push_back(cur);
        in_pkt = !dout_eop;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input logic [63:0] base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      din = base + 64'(i);
      din_vld = 1'b1;
      step();
      din_vld = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((pkt_pending != 0 || dout_vld) && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_drain"}, {72'd0, (k < budget)}, 73'd1);
  endtask

  // Expected words for vector positions 0..n-1 with burst length b.
  task automatic push_exp(input logic [63:0] base, input int n, input int b);
    logic [6:0] off;
    logic s, e;
    for (int p = 0; p < n; p++) begin
      off = p[6:0];
      s = (p % b) == 0;
      e = ((p % b) == b - 1) || (p == 99);
      exp_q.push_back({s, e, off, base + 64'(p)});
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 73'(cap_q.size()), 73'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) chk(tag, cap_q[i], exp_q[i]);
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_vld", {72'd0, dout_vld}, 73'd0);
    chk("rst_sop_eop", {71'd0, dout_sop, dout_eop}, 73'd0);
    chk("rst_ovf", {72'd0, overflow}, 73'd0);
    chk("rst_pending", 73'(pkt_pending), 73'd0);
    chk("rst_dout", 73'(dout), 73'd0);
    chk("rst_offset", 73'(dout_offset), 73'd0);
    rst = 1'b1;
    step();

    // mi=3 contiguous vector with 2-cycle sop latency
    rb_burst_len_mi = 32'd3;
    dout_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 64'(1000 + i);
      din_vld = 1'b1;
      step();
      if (i == 3) begin
        chk("lat_pending", 73'(pkt_pending), 73'd1);
        chk("lat_not_yet", {72'd0, dout_vld}, 73'd0);
      end
      if (i == 4) chk("lat_sop_word", {dout_vld, cur}, {1'b1, 1'b1, 1'b0, 7'd0, 64'd1000});
    end
    din_vld = 1'b0;
    wait_idle("b4", 200);
    push_exp(64'd1000, 100, 4);
    check_stream("b4");
    chk("b4_ovf", {72'd0, overflow}, 73'd0);

    // mi=7: twelve packets of 8 and a short final packet of 4
    rb_burst_len_mi = 32'd7;
    send_words(64'd2000, 100, 0);
    wait_idle("b8", 200);
    push_exp(64'd2000, 100, 8);
    check_stream("b8");

    // mi beyond FIFO depth clamps to 32; paced input so a full packet fits
    rb_burst_len_mi = 32'hFFFF_FFFF;
    send_words(64'd3000, 100, 1);
    wait_idle("b32", 400);
    push_exp(64'd3000, 100, 32);
    check_stream("b32");
    chk("b32_ovf", {72'd0, overflow}, 73'd0);

    // no drain: only 8 packets fit, the rest overflow
    rb_burst_len_mi = 32'd3;
    dout_rdy = 1'b0;
    send_words(64'd4000, 100, 0);
    chk("ovf_set", {72'd0, overflow}, 73'd1);
    chk("ovf_pending", 73'(pkt_pending), 73'd8);
    dout_rdy = 1'b1;
    wait_idle("ovf", 200);
    push_exp(64'd4000, 32, 4);
    check_stream("ovf");
    chk("ovf_sticky", {72'd0, overflow}, 73'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("ovf_cleared", {72'd0, overflow}, 73'd0);

    // sync discards the uncommitted tail of a packet
    dout_rdy = 1'b0;
    send_words(64'd0, 6, 0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_pending", 73'(pkt_pending), 73'd1);
    send_words(64'd100, 4, 0);
    chk("sync_pending2", 73'(pkt_pending), 73'd2);
    dout_rdy = 1'b1;
    wait_idle("sync", 100);
    push_exp(64'd0, 4, 4);
    push_exp(64'd100, 4, 4);
    check_stream("sync");

    // sync together with a word: that word takes offset 0
    send_words(64'd200, 2, 0);
    din = 64'd300;
    din_vld = 1'b1;
    sync = 1'b1;
    step();
    sync = 1'b0;
    din_vld = 1'b0;
    send_words(64'd301, 3, 0);
    wait_idle("sync_din", 100);
    push_exp(64'd300, 4, 4);
    check_stream("sync_din");

    // rdy toggling every cycle
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int i = 0; i < 100; i++) begin
      din = 64'(600 + i);
      din_vld = 1'b1;
      dout_rdy = ~dout_rdy;
      step();
      din_vld = 1'b0;
      repeat (2) begin
        dout_rdy = ~dout_rdy;
        step();
      end
    end
    for (int k = 0; k < 400 && (pkt_pending != 0 || dout_vld); k++) begin
      dout_rdy = ~dout_rdy;
      step();
    end
    chk("toggle_drain", {72'd0, (pkt_pending == 0 && !dout_vld)}, 73'd1);
    dout_rdy = 1'b1;
    push_exp(64'd600, 100, 4);
    check_stream("toggle");
    chk("toggle_ovf", {72'd0, overflow}, 73'd0);

    // clock enable low ignores inputs
    ce = 1'b0;
    send_words(64'd700, 4, 0);
    chk("ce_pending", 73'(pkt_pending), 73'd0);
    chk("ce_vld", {72'd0, dout_vld}, 73'd0);
    ce = 1'b1;

    // reset while a packet is being presented
    dout_rdy = 1'b0;
    send_words(64'd800, 4, 0);
    step();
    chk("pre_rst_vld", {72'd0, dout_vld}, 73'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {dout_vld, cur}, 74'd0);
    chk("mid_rst_pending", 73'(pkt_pending), 73'd0);
    step();
    rst = 1'b1;
    dout_rdy = 1'b1;
    send_words(64'd900, 8, 0);
    wait_idle("post_rst", 100);
    push_exp(64'd900, 8, 4);
    check_stream("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
